// File: rtl/solution_min_weight_if.sv
// axi_stream_if: AXI-Stream style channel carrying tdata/tvalid/tready/tlast
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/solution_min_weight.sv
// solution_min_weight: finds the minimum-popcount solution vector on a stream
module solution_min_weight #(
  parameter int MAX_VARS       = 16,
  parameter int MAX_VARS_W     = $clog2(MAX_VARS + 1),
  parameter int AXI_DATA_WIDTH = 8,
  parameter int COUNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MAX_VARS_W-1:0] vars,
  axi_stream_if.slave           solution_stream,
  output logic [MAX_VARS_W-1:0] min_weight,
  output logic [COUNT_W-1:0]    min_index,
  output logic [COUNT_W-1:0]    solution_count,
  output logic                  error,
  output logic                  result_valid,
  input  logic                  result_ready
);
  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;
  state_t state, state_nx;
  logic [MAX_VARS_W-1:0] vars_q, acc, beat, pop, weight;
  logic accept, last_beat, sol_end, better;
  int nbeats, base;
  assign solution_stream.tready = state == RECV;
  assign result_valid = state == REPORT;
  // beat geometry, masked popcount of the current beat and solution-end detection
  always_comb begin
    nbeats = vars_q == '0 ? 1 : (int'(vars_q) + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH;
    base = int'(beat) * AXI_DATA_WIDTH;
    pop = '0;
    for (int i = 0; i < AXI_DATA_WIDTH; i++)
      if (solution_stream.tdata[i] && base + i < int'(vars_q)) pop = pop + MAX_VARS_W'(1);
    weight = acc + pop;
    accept = solution_stream.tvalid && solution_stream.tready;
    last_beat = int'(beat) == nbeats - 1;
    sol_end = last_beat || solution_stream.tlast;
    better = weight < min_weight || solution_count == '0;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next-state logic; a start pulse only matters in IDLE
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = RECV;
    if (accept && solution_stream.tlast) state_nx = REPORT;
    if (state == REPORT && result_ready) state_nx = IDLE;
  end
  // job setup, per-beat weight accumulation and per-solution minimum tracking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vars_q <= '0;
      acc <= '0;
      beat <= '0;
      min_weight <= '0;
      min_index <= '0;
      solution_count <= '0;
      error <= 1'b0;
    end else if (state == IDLE && start) begin
      vars_q <= vars > MAX_VARS_W'(MAX_VARS) ? MAX_VARS_W'(MAX_VARS) : vars;
      acc <= '0;
      beat <= '0;
      min_weight <= '1;
      min_index <= '0;
      solution_count <= '0;
      error <= 1'b0;
    end else if (accept && sol_end) begin
      if (better) begin
        min_weight <= weight;
        min_index <= solution_count;
      end
      solution_count <= &solution_count ? solution_count : solution_count + COUNT_W'(1);
      acc <= '0;
      beat <= '0;
      error <= error | (solution_stream.tlast && !last_beat);
    end else if (accept) begin
      acc <= weight;
      beat <= beat + MAX_VARS_W'(1);
    end
endmodule

// File: tb/tb_solution_min_weight.sv
// tb_solution_min_weight: scoreboard bench for solution_min_weight
module tb_solution_min_weight;
  localparam int MV = 16;
  localparam int MVW = 5;
  localparam int W = 8;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic result_ready = 1'b0;
  logic [MVW-1:0] vars = '0;
  logic [MVW-1:0] min_weight;
  logic [CW-1:0] min_index, solution_count;
  logic error, result_valid;
  typedef struct packed {
    logic [MVW-1:0] w;
    logic [CW-1:0]  idx;
    logic [CW-1:0]  cnt;
    logic           err;
  } exp_t;
  exp_t sb[$];
  logic [31:0] sols[$];
  int checks = 0;
  int fails = 0;
  axi_stream_if #(.DATA_WIDTH(W)) s ();
  solution_min_weight #(.MAX_VARS(MV), .MAX_VARS_W(MVW), .AXI_DATA_WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .vars(vars), .solution_stream(s),
    .min_weight(min_weight), .min_index(min_index), .solution_count(solution_count),
    .error(error), .result_valid(result_valid), .result_ready(result_ready)
  );
  always #5 clk = ~clk;
  function automatic int eff_vars(input int v);
    return v > MV ? MV : v;
  endfunction
  function automatic int nb(input int v);
    return eff_vars(v) == 0 ? 1 : (eff_vars(v) + W - 1) / W;
  endfunction
  function automatic exp_t model(input int v);
    exp_t e;
    logic [31:0] mask;
    int wt, best;
    mask = eff_vars(v) == 0 ? 32'h0 : (32'h1 << eff_vars(v)) - 32'h1;
    best = 0;
    e = '0;
    for (int k = 0; k < sols.size(); k++) begin
      wt = $countones(sols[k] & mask);
      if (k == 0 || wt < best) begin
        best = wt;
        e.idx = CW'(k);
      end
    end
    e.w = MVW'(best);
    e.cnt = CW'(sols.size());
    return e;
  endfunction
  task automatic start_job(input int v);
    vars = MVW'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drive_beat(input logic [W-1:0] d, input logic l, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    s.tdata = d;
    s.tlast = l;
    s.tvalid = 1'b1;
    n = 0;
    while (!s.tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s.tready) begin
      fails++;
      $display("FAIL beat_accept: tready=%0b required 1 within 50 cycles", s.tready);
    end
    @(negedge clk);
    s.tvalid = 1'b0;
    s.tlast = 1'b0;
  endtask
  task automatic send_sols(input int v, input int maxgap);
    logic [31:0] t;
    for (int k = 0; k < sols.size(); k++)
      for (int b = 0; b < nb(v); b++) begin
        t = sols[k] >> (W * b);
        drive_beat(t[W-1:0], k == sols.size() - 1 && b == nb(v) - 1,
                   maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
      end
  endtask
  task automatic collect(input string name, input int hold);
    exp_t e;
    int n;
    n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!result_valid) begin
      fails++;
      $display("FAIL %s_valid: result_valid=%0b required 1", name, result_valid);
    end
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s_scoreboard: queue size=0 required 1", name);
      e = '0;
    end else e = sb.pop_front();
    checks++;
    if (min_weight !== e.w) begin
      fails++;
      $display("FAIL %s_weight: got %0d required %0d", name, min_weight, e.w);
    end
    checks++;
    if (min_index !== e.idx) begin
      fails++;
      $display("FAIL %s_index: got %0d required %0d", name, min_index, e.idx);
    end
    checks++;
    if (solution_count !== e.cnt) begin
      fails++;
      $display("FAIL %s_count: got %0d required %0d", name, solution_count, e.cnt);
    end
    checks++;
    if (error !== e.err) begin
      fails++;
      $display("FAIL %s_error: got %0b required %0b", name, error, e.err);
    end
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || min_weight !== e.w || min_index !== e.idx || solution_count !== e.cnt || error !== e.err) begin
        fails++;
        $display("FAIL %s_hold: valid=%0b w=%0d idx=%0d cnt=%0d err=%0b required 1/%0d/%0d/%0d/%0b",
                 name, result_valid, min_weight, min_index, solution_count, error, e.w, e.idx, e.cnt, e.err);
      end
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || s.tready !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: valid=%0b tready=%0b required 0/0", name, result_valid, s.tready);
    end
    @(negedge clk);
    checks++;
    if (min_weight !== e.w || solution_count !== e.cnt) begin
      fails++;
      $display("FAIL %s_idle_hold: w=%0d cnt=%0d required %0d/%0d", name, min_weight, solution_count, e.w, e.cnt);
    end
  endtask
  task automatic run_job(input string name, input int v, input int maxgap, input int hold);
    sb.push_back(model(v));
    start_job(v);
    send_sols(v, maxgap);
    collect(name, hold);
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (s.tready !== 1'b0 || result_valid !== 1'b0 || error !== 1'b0 || min_weight !== '0 || min_index !== '0 || solution_count !== '0) begin
      fails++;
      $display("FAIL reset: tready=%0b valid=%0b err=%0b w=%0d idx=%0d cnt=%0d required all 0",
               s.tready, result_valid, error, min_weight, min_index, solution_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_single();
    sols = '{32'h16};
    sb.push_back(model(5));
    start_job(5);
    checks++;
    if (s.tready !== 1'b1 || result_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_recv: tready=%0b valid=%0b required 1/0", s.tready, result_valid);
    end
    drive_beat(8'h16, 1'b1, 0);
    checks++;
    if (result_valid !== 1'b1) begin
      fails++;
      $display("FAIL single_latency: result_valid=%0b required 1", result_valid);
    end
    collect("single", 0);
  endtask
  task automatic test_multi();
    sols = '{32'h0FFF, 32'h0101, 32'h0030};
    run_job("multi", 12, 0, 0);
  endtask
  task automatic test_padding();
    sols = '{32'hE1};
    run_job("padding", 5, 0, 0);
  endtask
  task automatic test_backpressure();
    sols = '{32'h0FFF, 32'h0101, 32'h0030};
    run_job("backpressure", 12, 3, 3);
  endtask
  task automatic test_error();
    sb.push_back('{w: 5'd3, idx: 16'd0, cnt: 16'd1, err: 1'b1});
    start_job(12);
    drive_beat(8'h07, 1'b1, 0);
    collect("error", 1);
  endtask
  task automatic test_vars_zero();
    sols = '{32'hFF, 32'h00, 32'h5A};
    run_job("vars_zero", 0, 0, 0);
  endtask
  task automatic test_clamp();
    sols = '{32'hFFFFF, 32'h10001, 32'h30000};
    run_job("clamp", 20, 1, 0);
  endtask
  task automatic test_start_ignored();
    sols = '{32'h0F0, 32'h003};
    sb.push_back(model(12));
    start_job(12);
    drive_beat(8'hF0, 1'b0, 0);
    start_job(1);
    drive_beat(8'h00, 1'b0, 0);
    drive_beat(8'h03, 1'b0, 0);
    drive_beat(8'h00, 1'b1, 0);
    start_job(1);
    collect("start_ignored", 1);
  endtask
  task automatic test_back_to_back();
    sols = '{32'h0003, 32'h0F00, 32'h0001, 32'h0080};
    run_job("b2b_a", 16, 0, 0);
    sols = '{32'h7F, 32'h3F};
    run_job("b2b_b", 7, 0, 0);
  endtask
  task automatic test_reset_midjob();
    start_job(12);
    drive_beat(8'hFF, 1'b0, 0);
    drive_beat(8'h0F, 1'b0, 0);
    drive_beat(8'h33, 1'b0, 0);
    s.tdata = 8'hFF;
    s.tvalid = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (s.tready !== 1'b0 || result_valid !== 1'b0 || error !== 1'b0 || min_weight !== '0 || min_index !== '0 || solution_count !== '0) begin
      fails++;
      $display("FAIL reset_async: tready=%0b valid=%0b err=%0b w=%0d idx=%0d cnt=%0d required all 0",
               s.tready, result_valid, error, min_weight, min_index, solution_count);
    end
    @(negedge clk);
    rst = 1'b0;
    s.tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s.tready !== 1'b0 || solution_count !== '0 || min_weight !== '0) begin
      fails++;
      $display("FAIL reset_midjob: tready=%0b cnt=%0d w=%0d required 0/0/0", s.tready, solution_count, min_weight);
    end
    sols = '{32'h16};
    run_job("after_reset", 5, 0, 0);
  endtask
  initial begin
    s.tdata = '0;
    s.tvalid = 1'b0;
    s.tlast = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_padding();
    test_backpressure();
    test_error();
    test_vars_zero();
    test_clamp();
    test_start_ignored();
    test_back_to_back();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
